// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues PC fetches over a req/gnt memory channel, tags the
// in-order responses with their fetch address and buffers them for decode.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  drop;
  logic              active;
  logic [PTR_W-1:0]  buf_wptr;
  logic [PTR_W-1:0]  buf_rptr;
  logic [PTR_W-1:0]  tag_wptr;
  logic [PTR_W-1:0]  tag_rptr;
  logic [DATA_W-1:0] buf_instr [DEPTH];
  logic [ADDR_W-1:0] buf_pc    [DEPTH];
  logic [ADDR_W-1:0] tag_mem   [DEPTH];

  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              grant;
  logic              resp;
  logic              keep;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Credit covers both buffered words and words still owed by memory, so the buffer
  // can always absorb every response that is not being dropped.
  assign occupancy = {1'b0, outst} + {1'b0, count};
  assign credit_ok = occupancy < (CNT_W + 1)'(DEPTH);
  assign imem_req  = active & pc_valid & credit_ok & ~flush;
  assign imem_addr = pc_in;
  assign grant     = imem_req & imem_gnt;
  assign pc_ready  = grant;

  assign resp      = imem_rvalid & (outst != '0);
  assign keep      = resp & (drop == '0) & ~flush;
  assign pop       = (count != '0) & if_ready & ~flush;

  assign if_valid  = (count != '0);
  assign if_instr  = buf_instr[buf_rptr];
  assign if_pc     = buf_pc[buf_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      buf_wptr <= '0;
      buf_rptr <= '0;
      tag_wptr <= '0;
      tag_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
        tag_mem[i]   <= '0;
      end
    end else begin
      active <= 1'b1;
      outst  <= outst + CNT_W'(grant) - CNT_W'(resp);
      if (flush) begin
        // Every outstanding response becomes a drop; earlier drops are already part of
        // outst, so they are not added again.
        drop     <= outst - CNT_W'(resp);
        count    <= '0;
        buf_wptr <= '0;
        buf_rptr <= '0;
        tag_wptr <= '0;
        tag_rptr <= '0;
      end else begin
        if (resp && (drop != '0)) begin
          drop <= drop - CNT_W'(1);
        end
        if (grant) begin
          tag_mem[tag_wptr] <= pc_in;
          tag_wptr          <= next_ptr(tag_wptr);
        end
        if (keep) begin
          buf_instr[buf_wptr] <= imem_rdata;
          buf_pc[buf_wptr]    <= tag_mem[tag_rptr];
          buf_wptr            <= next_ptr(buf_wptr);
          tag_rptr            <= next_ptr(tag_rptr);
        end
        if (pop) begin
          buf_rptr <= next_ptr(buf_rptr);
        end
        count <= count + CNT_W'(keep) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: granted fetches are queued as expected deliveries,
// a negedge monitor compares every decode handshake against that queue.
module tb_instr_fetch;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mreq_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            lat = 1;
  bit            var_lat = 1'b0;
  bit            spur_auto = 1'b0;
  bit            spur_once = 1'b0;
  bit            adv = 1'b0;
  int            grant_cnt = 0;
  int            first_gnt_cyc = -1;
  int            first_del_cyc = -1;
  logic [AW-1:0] pc_end;
  logic [AW-1:0] exp_pc;
  mreq_t         mq[$];
  mreq_t         mnew;
  logic [AW-1:0] pend[$];
  logic [AW-1:0] got[$];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model and PC driver: act 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (adv) pc_in = pc_in + 16'd1;
    pc_valid    = (pc_in != pc_end);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else if (mq.size() == 0 && (spur_auto || spur_once)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
      spur_once   = 1'b0;
    end
  end

  // Monitor / scoreboard on the falling edge.
  always @(negedge clk) begin
    adv = 1'b0;
    if (rst_n) begin
      check("pc_ready_vs_req_gnt", pc_ready, imem_req & imem_gnt);
      if (if_valid && if_ready && !flush) begin
        if (first_del_cyc < 0) first_del_cyc = cyc;
        got.push_back(if_pc);
        if (pend.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got if_pc=%h expected no delivery", if_pc);
        end else begin
          exp_pc = pend.pop_front();
          check("deliver_pc", if_pc, exp_pc);
          check("deliver_instr", if_instr, word_of(exp_pc));
        end
      end
      if (flush) pend.delete();
      if (imem_req && imem_gnt) begin
        check("req_addr", imem_addr, pc_in);
        grant_cnt++;
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        adv = 1'b1;
        pend.push_back(pc_in);
        mnew.addr = pc_in;
        mnew.due  = cyc + (var_lat ? 1 + (grant_cnt % 4) : lat);
        mq.push_back(mnew);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_pc(input logic [AW-1:0] a, input logic [AW-1:0] e);
    pc_in    = a;
    pc_end   = e;
    pc_valid = (a != e);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((pend.size() > 0 || mq.size() > 0 || pc_valid) && k < budget) begin
      step();
      k++;
    end
    step(2);
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, pend.size());
    end
  endtask

  task automatic wait_grants(input string name, input int target);
    int k = 0;
    while (grant_cnt < target && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_grant_timeout: got %0d grants expected %0d", name, grant_cnt, target);
    end
  endtask

  task automatic check_list(input string name, input logic [AW-1:0] start, input int n);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({name, "_order"}, got[i], start + AW'(i));
    end
  endtask

  initial begin
    int g0;
    rst_n = 1'b0; flush = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1;
    set_pc(16'h0100, 16'h0101);
    // Test 1: reset with pc_valid held high
    step(3);
    @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_ready", pc_ready, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_if_instr", if_instr, 16'h0000);
    step();
    rst_n = 1'b1;
    begin
      int k = 0;
      @(negedge clk);
      while (!imem_req && k < 5) begin
        @(negedge clk);
        k++;
      end
      check("first_req_seen", imem_req, 1'b1);
      check("first_req_addr", imem_addr, 16'h0100);
    end
    step();
    drain("t1", 30);
    check("min_latency", first_del_cyc - first_gnt_cyc, 2);
    check_list("t1", 16'h0100, 1);

    // Test 2: streaming with one-cycle memory
    got.delete();
    set_pc(16'h0000, 16'h0004);
    drain("t2", 40);
    check_list("t2", 16'h0000, 4);

    // Test 3: back-pressure from decode
    got.delete();
    if_ready = 1'b0;
    g0 = grant_cnt;
    set_pc(16'h0010, 16'h0018);
    step(6);
    @(negedge clk);
    check("t3_grants_while_stalled", grant_cnt - g0, DEPTH);
    check("t3_pc_ready_stalled", pc_ready, 1'b0);
    check("t3_if_valid_stalled", if_valid, 1'b1);
    step();
    if_ready = 1'b1;
    drain("t3", 60);
    check_list("t3", 16'h0010, 8);

    // Test 4: flush with two fetches in flight
    got.delete();
    lat = 3;
    g0 = grant_cnt;
    set_pc(16'h0004, 16'h0006);
    wait_grants("t4", g0 + 2);
    flush = 1'b1;
    set_pc(16'h0020, 16'h0022);
    @(negedge clk);
    check("t4_no_req_in_flush", imem_req, 1'b0);
    step();
    flush = 1'b0;
    drain("t4", 60);
    check_list("t4", 16'h0020, 2);
    lat = 1;

    // Test 5: flush coincident with a response and a decode pop
    got.delete();
    g0 = grant_cnt;
    set_pc(16'h0030, 16'h0032);
    wait_grants("t5", g0 + 2);
    flush = 1'b1;
    set_pc(16'h0040, 16'h0041);
    @(negedge clk);
    check("t5_if_valid_in_flush", if_valid, 1'b1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t5_if_valid_after_flush", if_valid, 1'b0);
    drain("t5", 60);
    check_list("t5", 16'h0040, 1);

    // Test 6: spurious responses and variable memory latency
    got.delete();
    spur_once = 1'b1;
    step();
    @(negedge clk);
    check("t6_spur_if_valid_a", if_valid, 1'b0);
    step();
    @(negedge clk);
    check("t6_spur_if_valid_b", if_valid, 1'b0);
    step();
    var_lat = 1'b1;
    spur_auto = 1'b1;
    set_pc(16'h0050, 16'h0058);
    for (int k = 0; k < 60; k++) begin
      if_ready = (k % 3) != 0;
      imem_gnt = (k % 4) != 1;
      step();
    end
    if_ready = 1'b1;
    imem_gnt = 1'b1;
    drain("t6", 80);
    spur_auto = 1'b0;
    step(2);
    check_list("t6", 16'h0050, 8);
    @(negedge clk);
    check("final_if_valid", if_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
